// File: rtl/vga_pkg.sv
// Shared definitions for the VGA frame reader.
// Holds the default 640x480@60 timing, the default image geometry and
// memory map, and the control bundle that runs beside the memory read.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int DEF_IMG_W  = 256;
  localparam int DEF_IMG_H  = 256;
  localparam int DEF_BASE_A = 0;
  localparam int DEF_BASE_B = 65536;
  localparam int DEF_ADDR_W = 18;

  // Control bits that travel one stage alongside the memory read.
  // Sync flags are active high here; the output stage inverts them.
  typedef struct packed {
    logic hs_act;
    logic vs_act;
    logic in_img;
    logic en;
  } pix_ctl_t;

  // Grayscale byte replicated onto all three colour channels.
  function automatic logic [23:0] gray_to_rgb(input logic [7:0] g);
    return {g, g, g};
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters for the VGA frame reader.
// Ports:
//   clk_i        pixel clock
//   rst_ni       synchronous active-low reset (counters to 0,0)
//   hs_act_o     horizontal sync region, active high
//   vs_act_o     vertical sync region, active high
//   in_img_o     current position lies inside the top-left image
//   origin_o     counters at (0,0)
//   frame_end_o  counters at the last position; next clock is (0,0)
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int IMG_W    = DEF_IMG_W,
  parameter int IMG_H    = DEF_IMG_H
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic hs_act_o,
  output logic vs_act_o,
  output logic in_img_o,
  output logic origin_o,
  output logic frame_end_o
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [HW-1:0] IMG_W_C  = HW'(IMG_W);
  localparam logic [VW-1:0] IMG_H_C  = VW'(IMG_H);

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          h_last, v_last;

  assign h_last = (hcnt_q == H_LAST);
  assign v_last = (vcnt_q == V_LAST);

  // vcnt only moves when hcnt wraps; both wrap together at the frame end.
  always_comb begin
    hcnt_d = hcnt_q + 1'b1;
    vcnt_d = vcnt_q;
    if (h_last) begin
      hcnt_d = '0;
      vcnt_d = v_last ? '0 : vcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  assign hs_act_o    = (hcnt_q >= HS_START) && (hcnt_q < HS_END);
  assign vs_act_o    = (vcnt_q >= VS_START) && (vcnt_q < VS_END);
  assign in_img_o    = (hcnt_q < IMG_W_C) && (vcnt_q < IMG_H_C);
  assign origin_o    = (hcnt_q == '0) && (vcnt_q == '0);
  assign frame_end_o = h_last && v_last;

endmodule

// File: rtl/vga_frame_reader.sv
// VGA display stage: raster timing, image memory fetch and DAC output.
// Ports:
//   clk           pixel clock, rising edge
//   reset         synchronous active-low reset
//   enable        display enable; low blanks the pixel output
//   image_select  0 = image at BASE_A, 1 = image at BASE_B (frame boundary only)
//   mem_addr      read address to image memory
//   mem_rden      read enable to image memory
//   mem_data      pixel byte, valid one clock after mem_addr/mem_rden
//   hsync, vsync  active-low syncs
//   rgb_out       {R,G,B} pixel colour
//   frame_start   one-clock pulse with the first pixel of each frame
// hsync, vsync, rgb_out and frame_start lag the raster position by 2 clocks.
module vga_frame_reader
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int IMG_W    = DEF_IMG_W,
  parameter int IMG_H    = DEF_IMG_H,
  parameter int BASE_A   = DEF_BASE_A,
  parameter int BASE_B   = DEF_BASE_B,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              image_select,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rden,
  input  logic [7:0]        mem_data,
  output logic              hsync,
  output logic              vsync,
  output logic [23:0]       rgb_out,
  output logic              frame_start
);

  localparam logic [ADDR_W-1:0] BASE_A_C = ADDR_W'(BASE_A);
  localparam logic [ADDR_W-1:0] BASE_B_C = ADDR_W'(BASE_B);

  logic hs_act, vs_act, in_img, origin, frame_end;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .IMG_W    (IMG_W),
    .IMG_H    (IMG_H)
  ) u_timing (
    .clk_i       (clk),
    .rst_ni      (reset),
    .hs_act_o    (hs_act),
    .vs_act_o    (vs_act),
    .in_img_o    (in_img),
    .origin_o    (origin),
    .frame_end_o (frame_end)
  );

  // Stage 0: frame-select latch and running read address
  logic              sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  // The select is captured on the edge that moves the raster to (0,0), so
  // the base address is already in place for the first pixel of the frame.
  always_comb begin
    sel_d  = sel_q;
    addr_d = addr_q;
    if (frame_end) begin
      sel_d  = image_select;
      addr_d = sel_d ? BASE_B_C : BASE_A_C;
    end else if (in_img) begin
      addr_d = addr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sel_q  <= 1'b0;
      addr_q <= BASE_A_C;
    end else begin
      sel_q  <= sel_d;
      addr_q <= addr_d;
    end
  end

  assign mem_addr = addr_q;
  // Gated by reset so no read is issued while the block is held in reset.
  assign mem_rden = in_img && enable && reset;

  // Stage 1: control bundle waits for the memory read
  pix_ctl_t ctl_p1_q;
  logic     origin_p1_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      ctl_p1_q    <= '0;
      origin_p1_q <= 1'b0;
    end else begin
      ctl_p1_q    <= '{hs_act: hs_act, vs_act: vs_act, in_img: in_img, en: enable};
      origin_p1_q <= origin;
    end
  end

  // Stage 2: output registers
  logic        hsync_p2_q, vsync_p2_q, frame_start_p2_q;
  logic [23:0] rgb_p2_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      hsync_p2_q       <= 1'b1;
      vsync_p2_q       <= 1'b1;
      rgb_p2_q         <= '0;
      frame_start_p2_q <= 1'b0;
    end else begin
      hsync_p2_q       <= ~ctl_p1_q.hs_act;
      vsync_p2_q       <= ~ctl_p1_q.vs_act;
      rgb_p2_q         <= (ctl_p1_q.in_img && ctl_p1_q.en) ? gray_to_rgb(mem_data) : 24'h0;
      frame_start_p2_q <= origin_p1_q;
    end
  end

  assign hsync       = hsync_p2_q;
  assign vsync       = vsync_p2_q;
  assign rgb_out     = rgb_p2_q;
  assign frame_start = frame_start_p2_q;

endmodule

// File: doc/vga_frame_reader.md
Name: vga_frame_reader

Overview:
- Display-side stage downstream of the image memory.
- Generates 640x480@60 VGA timing and fetches grayscale pixels from the image memory read port, one pixel per clock.
- Drives hsync, vsync and rgb_out to the DAC.
- Selects between the original image and the interpolated image buffer, with the selection changing only on frame boundaries.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
IMG_W, 256, displayed image width (pixels)
IMG_H, 256, displayed image height (pixels)
BASE_A, 0, word address of the original image
BASE_B, 65536, word address of the interpolated image
ADDR_W, 18, memory address width

Ports:
clk  input  1  pixel clock; all logic on rising edge
reset  input  1  synchronous, active-low reset
enable  input  1  display enable; low blanks the pixel output
image_select  input  1  0 = image at BASE_A, 1 = image at BASE_B
mem_addr  output  ADDR_W  read address to image memory
mem_rden  output  1  read enable to image memory
mem_data  input  8  pixel byte; valid 1 clock after mem_addr/mem_rden
hsync  output  1  horizontal sync, active low
vsync  output  1  vertical sync, active low
rgb_out  output  24  pixel colour {R,G,B}
frame_start  output  1  one-clock pulse at the first pixel of each frame

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low (reset=0 sampled at a rising edge).
- Counters:
  - hcnt runs 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800.
  - vcnt runs 0..V_TOTAL-1, where V_TOTAL = 525.
  - vcnt increments when hcnt wraps to 0.
  - Both counters wrap to 0 together at (799,524).
- Regions:
  - Sync active for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - Sync active for V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491.
  - in_img = (hcnt < IMG_W) && (vcnt < IMG_H). Image is top-left aligned.
- Frame-boundary sampling:
  - At hcnt=0, vcnt=0, sel_q <= image_select and the address register loads BASE_A or BASE_B accordingly.
  - image_select is ignored at all other times; no mid-frame tearing.
- Address generation:
  - Running address register, no multiplier.
  - mem_addr = current address; mem_rden = in_img && enable.
  - The address increments by 1 after each in_img cycle, so the image is read row-major, contiguously.
  - Final address of a frame is base + IMG_W*IMG_H - 1. It does not wrap within ADDR_W.
- Pipeline, fixed 2-clock latency:
  - Stage 0: counters, mem_addr, mem_rden.
  - Stage 1: memory returns mem_data; sync, in_img and enable are delayed one stage.
  - Stage 2: output registers.
    - hsync and vsync are the stage-1 sync values inverted (active low).
    - rgb_out = {mem_data, mem_data, mem_data} if the delayed in_img && enable, else 24'h0.
  - hsync, vsync and rgb_out are mutually aligned and lag the counter position by exactly 2 clocks.
  - frame_start uses the same 2-clock delay as the counters (0,0).
- enable=0: counters and sync keep running; mem_rden=0; rgb_out=0 from 2 clocks later.
- Reset values, held while reset=0:
  - hcnt=0, vcnt=0, sel_q=0, address=BASE_A.
  - mem_rden=0, hsync=1, vsync=1, rgb_out=0, frame_start=0.
  - All pipeline registers cleared.
- Reset mid-frame: the next clock after release begins a fresh frame at (0,0); no stale pixel emerges from the pipeline.
- Simultaneous events: the horizontal wrap and vertical wrap at (799,524) take priority as a single transition to (0,0) with frame reload.

Decomposition:
- Package vga_pkg:
  - Default timing constants.
  - H_TOTAL and V_TOTAL localparams.
  - Typedef for the {hsync, vsync, in_img, enable} pipeline bundle.
- Sub-module vga_timing:
  - Owns the hcnt/vcnt counters.
  - Outputs raw sync, in_img and frame-origin flags.
- vga_frame_reader holds the address register, frame-select latch and output pipeline.

Test Plan:
- Reset held 5 clocks, then released: all outputs at reset values during reset; frame_start pulses 2 clocks after the counters reach (0,0), and on each subsequent frame every 420000 clocks.
- Line timing, checked in clocks after the line start (counter hcnt=0) plus 2: hsync low for exactly 96 clocks starting at 656+2; vsync low for exactly 2 lines (1600 clocks), lines 490-491.
- image_select=0, memory model returning data = addr[7:0]: line 0 shows mem_addr BASE_A..BASE_A+255; line 1 starts at 256; rgb_out at pixel (5,1) equals 24'h050505; pixel (300,0) equals 0.
- image_select toggled to 1 at line 100: addresses stay in BASE_A space until the frame ends; the next frame begins at mem_addr=65536.
- enable dropped for one line: mem_rden=0 and rgb_out=0 for that line; hsync/vsync cadence unchanged.
- reset asserted at hcnt=400, vcnt=120 for 1 clock: outputs return to reset values; the frame restarts at address BASE_A with no residual nonzero rgb_out.
